// File: rtl/tff_toggle_monitor_if.sv
// Result channel of the toggle monitor: one window count per valid/ready transfer,
// plus the sticky overrun flag and its clear.
interface tff_toggle_monitor_if #(
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0] count_data;
  logic             count_valid;
  logic             count_ready;
  logic             overrun;
  logic             clr_overrun;

  modport master (
    output count_data,
    output count_valid,
    output overrun,
    input  count_ready,
    input  clr_overrun
  );

  modport slave (
    input  count_data,
    input  count_valid,
    input  overrun,
    output count_ready,
    output clr_overrun
  );
endinterface

// File: rtl/tff_toggle_monitor.sv
// Synchronises a T-flop Q, pulses rise/fall SYNC_STAGES cycles after a change, counts toggles per
// WINDOW enabled cycles; a result meeting a still-pending one under backpressure is dropped (overrun).
module tff_toggle_monitor #(
  parameter int CNT_W       = 8,
  parameter int WINDOW      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  q_in,
  input  logic                  en,
  output logic                  rise,
  output logic                  fall,
  tff_toggle_monitor_if.master  res
);

  localparam int               TW      = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [TW-1:0]    LAST    = TW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   q_sync;
  logic                   q_prev;
  logic                   ev;
  logic                   win_end;
  logic                   xfer;
  logic                   drop;
  logic [TW-1:0]          timer;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       result;

  assign q_sync  = sync_q[SYNC_STAGES-1];
  assign ev      = rise | fall;
  assign win_end = en & (timer == LAST);
  // Saturating increment; at window end this also folds in an event from the closing cycle.
  assign result  = (ev && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;
  assign xfer    = res.count_valid & res.count_ready;
  assign drop    = win_end & res.count_valid & ~res.count_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      q_prev <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
      q_prev <= q_sync;
      rise   <= q_sync & ~q_prev;
      fall   <= ~q_sync & q_prev;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
      cnt   <= '0;
    end else if (en) begin
      if (win_end) begin
        timer <= '0;
        cnt   <= '0;
      end else begin
        timer <= timer + 1'b1;
        cnt   <= result;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res.count_data  <= '0;
      res.count_valid <= 1'b0;
      res.overrun     <= 1'b0;
    end else begin
      // A reload may coincide with a transfer; otherwise data is frozen while valid.
      if (win_end && (!res.count_valid || res.count_ready)) begin
        res.count_data  <= result;
        res.count_valid <= 1'b1;
      end else if (xfer) begin
        res.count_valid <= 1'b0;
      end

      if (drop) begin
        res.overrun <= 1'b1;
      end else if (res.clr_overrun) begin
        res.overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tff_toggle_monitor.sv
// Directed bench: window results go through per-DUT scoreboards; edge timing, hold, overrun and reset checked inline.
module tb_tff_toggle_monitor;

  logic clk = 1'b0;
  logic reset;
  logic q_in, en, rise, fall;
  logic q_b, en_b, rise_b, fall_b;

  int n_chk  = 0;
  int n_fail = 0;
  int q_a[$];
  int q_bq[$];

  tff_toggle_monitor_if #(.CNT_W(8)) ifa ();
  tff_toggle_monitor_if #(.CNT_W(3)) ifb ();

  tff_toggle_monitor #(.CNT_W(8), .WINDOW(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset(reset), .q_in(q_in), .en(en),
    .rise(rise), .fall(fall), .res(ifa)
  );

  tff_toggle_monitor #(.CNT_W(3), .WINDOW(16), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset(reset), .q_in(q_b), .en(en_b),
    .rise(rise_b), .fall(fall_b), .res(ifb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a transfer is whatever the DUT sees at the coming edge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("rf_excl_a", int'(rise & fall), 0);
      chk("rf_excl_b", int'(rise_b & fall_b), 0);
      if (ifa.count_valid && ifa.count_ready) begin
        if (q_a.size() == 0) chk("sb_a_extra", q_a.size(), 1);
        else chk("sb_a_data", int'(ifa.count_data), q_a.pop_front());
      end
      if (ifb.count_valid && ifb.count_ready) begin
        if (q_bq.size() == 0) chk("sb_b_extra", q_bq.size(), 1);
        else chk("sb_b_data", int'(ifb.count_data), q_bq.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0;
    q_in  = 1'b0;
    en    = 1'b1;
    q_b   = 1'b0;
    en_b  = 1'b0;
    ifa.count_ready = 1'b1;
    ifa.clr_overrun = 1'b0;
    ifb.count_ready = 1'b1;
    ifb.clr_overrun = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(ifa.count_valid), 0);
    chk("rst_data", int'(ifa.count_data), 0);
    chk("rst_overrun", int'(ifa.overrun), 0);
    chk("rst_edges", int'(rise | fall), 0);
    chk("rst_valid_b", int'(ifb.count_valid), 0);

    // Idle windows: results after edges 16, 32, 48.
    q_a.push_back(0); q_a.push_back(0); q_a.push_back(0);
    reset = 1'b1;
    for (int e = 1; e <= 48; e++) begin
      tick(1);
      chk("idle_valid", int'(ifa.count_valid), (e % 16 == 0) ? 1 : 0);
      chk("idle_edges", int'(rise | fall), 0);
    end

    // Edge latency: rise after 51, fall after 55; window 4 holds both.
    q_a.push_back(2);
    q_in = 1'b1;
    for (int e = 49; e <= 56; e++) begin
      tick(1);
      if (e == 52) q_in = 1'b0;
      chk("lat_rise", int'(rise), (e == 51) ? 1 : 0);
      chk("lat_fall", int'(fall), (e == 55) ? 1 : 0);
    end
    tick(8);

    // Toggle every 2 cycles: first window catches 7, then 8 each.
    q_a.push_back(7); q_a.push_back(8); q_a.push_back(8); q_a.push_back(8);
    for (int j = 0; j < 31; j++) begin
      q_in = ~q_in;
      tick(2);
    end
    tick(2);
    chk("steady_overrun", int'(ifa.overrun), 0);

    // Saturation on the 3-bit instance; A sees three empty windows.
    q_a.push_back(0); q_a.push_back(0); q_a.push_back(0);
    q_bq.push_back(7); q_bq.push_back(7); q_bq.push_back(7);
    en_b = 1'b1;
    for (int j = 0; j < 48; j++) begin
      q_b = ~q_b;
      tick(1);
    end
    en_b = 1'b0;

    // Backpressure: window 12 = 1 held, window 13 = 2 dropped.
    q_a.push_back(1);
    tick(1);
    ifa.count_ready = 1'b0;
    q_in = 1'b0;
    tick(15);
    chk("bp_valid", int'(ifa.count_valid), 1);
    chk("bp_data", int'(ifa.count_data), 1);
    tick(1); q_in = 1'b1;
    tick(2); q_in = 1'b0;
    for (int e = 196; e <= 207; e++) begin
      tick(1);
      chk("bp_hold_valid", int'(ifa.count_valid), 1);
      chk("bp_hold_data", int'(ifa.count_data), 1);
      chk("bp_no_ovr", int'(ifa.overrun), 0);
    end
    tick(1);
    chk("bp_ovr_set", int'(ifa.overrun), 1);
    chk("bp_ovr_data", int'(ifa.count_data), 1);
    tick(2); ifa.count_ready = 1'b1;
    tick(1); ifa.count_ready = 1'b0;
    chk("drain_valid", int'(ifa.count_valid), 0);
    chk("drain_data", int'(ifa.count_data), 1);
    tick(1); ifa.clr_overrun = 1'b1;
    tick(1); ifa.clr_overrun = 1'b0;
    chk("clr_ovr", int'(ifa.overrun), 0);
    tick(1); q_in = 1'b1;
    tick(10);
    chk("w14_valid", int'(ifa.count_valid), 1);
    chk("w14_data", int'(ifa.count_data), 1);
    tick(15); ifa.clr_overrun = 1'b1;
    tick(1); ifa.clr_overrun = 1'b0;
    chk("set_wins", int'(ifa.overrun), 1);
    chk("drop_keeps_data", int'(ifa.count_data), 1);

    // Hold: 10 disabled cycles push window end from edge 256 to 266.
    q_a.push_back(1); q_a.push_back(2);
    ifa.count_ready = 1'b1;
    q_in = 1'b0;
    tick(4); en = 1'b0;
    tick(2); q_in = 1'b1;
    tick(3);
    chk("hold_rise", int'(rise), 1);
    tick(5); en = 1'b1;
    tick(2);
    chk("hold_no_end", int'(ifa.count_valid), 0);
    q_in = 1'b0;
    tick(9);
    chk("hold_pre_end", int'(ifa.count_valid), 0);
    tick(1);
    chk("hold_end_valid", int'(ifa.count_valid), 1);
    chk("hold_end_data", int'(ifa.count_data), 2);

    // Asynchronous reset with a result pending and a fall pulse live.
    tick(1);
    ifa.count_ready = 1'b0;
    q_in = 1'b1;
    tick(30); q_in = 1'b0;
    tick(3);
    chk("pre_rst_valid", int'(ifa.count_valid), 1);
    chk("pre_rst_data", int'(ifa.count_data), 1);
    chk("pre_rst_ovr", int'(ifa.overrun), 1);
    chk("pre_rst_fall", int'(fall), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", int'(ifa.count_valid), 0);
    chk("arst_data", int'(ifa.count_data), 0);
    chk("arst_ovr", int'(ifa.overrun), 0);
    chk("arst_rise", int'(rise), 0);
    chk("arst_fall", int'(fall), 0);

    q_in = 1'b1;
    ifa.count_ready = 1'b1;
    q_a.push_back(1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick(1);
      chk("restart_valid", int'(ifa.count_valid), (e == 16) ? 1 : 0);
    end
    tick(3);
    chk("sb_a_left", q_a.size(), 0);
    chk("sb_b_left", q_bq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tff_toggle_monitor.md
Name: tff_toggle_monitor

Overview:
- Downstream consumer of the T-flip-flop output Q.
- Synchronises Q and reports single-cycle rise/fall events.
- Counts toggles over fixed windows of clock cycles.
- Delivers each window's count through a valid/ready handshake, with a sticky overrun flag for results lost to backpressure.

Parameters:
- CNT_W, 8, width of toggle count and count_data.
- WINDOW, 16, window length in clock cycles; legal range ≥ 2.
- SYNC_STAGES, 2, synchroniser depth on q_in; legal range ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- q_in  input  1  Q from the T-flip-flop stage; treated as asynchronous.
- en  input  1  1 = window timer and toggle counting run; 0 = both hold.
- rise  output  1  one-cycle pulse per synchronised 0→1 of q_in.
- fall  output  1  one-cycle pulse per synchronised 1→0 of q_in.
- count_data  output  CNT_W  toggle count of the last completed window.
- count_valid  output  1  count_data holds an unconsumed result.
- count_ready  input  1  consumer accepts count_data when high at a clk edge with count_valid=1.
- overrun  output  1  sticky: a window result was dropped.
- clr_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset asynchronously clears all state while low:
  - synchroniser chain, q_prev, rise, fall;
  - toggle counter, window timer;
  - count_data=0, count_valid=0, overrun=0.
  - A pending result is discarded.
- Synchroniser:
  - q_in passes through SYNC_STAGES flops; the last stage is q_sync; q_prev registers q_sync.
  - The synchroniser runs regardless of en.
- Edge detect, registered:
  - rise <= q_sync & ~q_prev; fall <= ~q_sync & q_prev.
  - Latency: q_in stable before edge k gives rise/fall high for exactly one cycle, after edge k+SYNC_STAGES.
  - rise and fall are never high together.
- Event: ev = rise | fall.
- Window timer:
  - When en=1, counts 0..WINDOW-1 and wraps to 0.
  - When en=0, timer and toggle counter hold; rise/fall still report.
  - Window end = en=1 and timer==WINDOW-1.
- Toggle counter:
  - On en=1 and ev=1 (not window end): cnt <= cnt+1, saturating at 2^CNT_W-1.
  - At window end, result = sat(cnt+ev), so an event in the closing cycle belongs to the closing window; cnt <= 0.
- Result handshake:
  - Transfer occurs at a clk edge with count_valid=1 and count_ready=1.
  - Window end with count_valid=0, or with a transfer in the same cycle: count_data <= result, count_valid stays/becomes 1.
  - Window end with count_valid=1 and count_ready=0: new result dropped; count_data and count_valid unchanged; overrun <= 1.
  - Transfer without window end: count_valid <= 0; count_data holds its value.
  - count_data must not change while count_valid=1 except on a same-cycle transfer plus reload.
- overrun:
  - Stays 1 until clr_overrun=1 at a clk edge.
  - If a clear and a new drop occur in the same cycle, the set wins.
- No combinational path from any input to any output.

Test Plan:
1. Idle windows: reset low 3 cycles, then high; en=1, q_in=0, count_ready=1, WINDOW=16 → count_valid high one cycle after edges 16, 32, 48 from release; count_data=0; rise=fall=0.
2. Edge latency: q_in 0→1 before edge k → rise=1 for exactly one cycle after edge k+2 (SYNC_STAGES=2); later 1→0 → single fall pulse, same latency; no overlap.
3. Steady toggling: q_in inverts every 2 cycles, ready=1 → from the second window on, count_data=8 every window; no overrun.
4. Saturation: CNT_W=3, q_in inverts every cycle, WINDOW=16 → count_data=7 every window; counter never wraps to 0 mid-window.
5. Backpressure:
   - count_ready=0 across two window ends → first result held stable with count_valid=1; overrun=1 after the second window end; second result lost.
   - Then ready=1 for 1 cycle → count_valid=0.
   - clr_overrun pulse → overrun=0.
   - clr_overrun in the same cycle as a new drop → overrun stays 1.
6. Hold and reset:
   - en=0 for 10 cycles mid-window → no window end; timer and count frozen.
   - With count_valid=1 pending, assert reset between edges → count_valid, count_data, overrun, rise, fall go to 0 immediately, without waiting for clk.
   - After release, the first result arrives 16 enabled cycles later.
